// File: rtl/demux_1to2_pipe_pkg.sv
// Shared constants and types for the registered 1-to-2 demultiplexer.
// Buffer depth, transfer-counter width and the per-edge buffer operation code.
package demux_1to2_pipe_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 16;
    localparam int CNT_BITS  = $clog2(BUF_DEPTH + 1);

    // Encoding is {push, pop} so the code can be built by a plain cast.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } bufOp_e;

    function automatic bufOp_e makeOp(input logic push, input logic pop);
        return bufOp_e'({push, pop});
    endfunction

endpackage

// File: rtl/demux_1to2_pipe_skid_buf.sv
// Two-entry in-order buffer (demux_skid_buf) feeding one demux output path.
// The head entry drives data_o directly, so a push is visible one edge later.
module demux_skid_buf
    import demux_1to2_pipe_pkg::*;
#(
    parameter int size = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [size-1:0] data_i,
    input  logic            ready_i,
    output logic [size-1:0] data_o,
    output logic            valid_o,
    output logic            full_o
);

    logic [size-1:0]     head_q, head_d;
    logic [size-1:0]     tail_q, tail_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                pop;
    bufOp_e              op;

    // State register; reset clears both entries so data_o reads 0 after reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Next state: an empty buffer keeps its old head so data_o holds its last value.
    always_comb begin
        pop     = ready_i && (count_q != '0);
        op      = makeOp(push_i, pop);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (op)
            OP_PUSH: begin
                if (count_q == '0) begin
                    head_d = data_i;
                end else begin
                    tail_d = data_i;
                end
                count_d = count_q + CNT_BITS'(1);
            end
            OP_POP: begin
                if (count_q == CNT_BITS'(BUF_DEPTH)) begin
                    head_d = tail_q;
                end
                count_d = count_q - CNT_BITS'(1);
            end
            OP_BOTH: begin
                if (count_q == CNT_BITS'(1)) begin
                    head_d = data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = data_i;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_comb begin
        data_o  = head_q;
        valid_o = (count_q != '0);
        full_o  = (count_q == CNT_BITS'(BUF_DEPTH));
    end

endmodule

// File: rtl/demux_1to2_pipe.sv
// Registered 1-to-2 demultiplexer with valid/ready on every side.
// Optional per-path transfer counters are enabled with DEMUX_1TO2_CNT_EN.
module demux_1to2_pipe
    import demux_1to2_pipe_pkg::*;
#(
    parameter int size = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [size-1:0]  data_i,
    input  logic             select_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [size-1:0]  data0_o,
    output logic             valid0_o,
    input  logic             ready0_i,
    output logic [size-1:0]  data1_o,
    output logic             valid1_o,
    input  logic             ready1_i
`ifdef DEMUX_1TO2_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o
`endif
);

    logic full0, full1;
    logic push0, push1;
    logic accept;

    // Readiness looks only at the selected buffer, never at valid_i or consumer ready.
    always_comb begin
        ready_o = select_i ? ~full1 : ~full0;
        accept  = valid_i && ready_o;
        push0   = accept && !select_i;
        push1   = accept &&  select_i;
    end

    demux_skid_buf #(.size(size)) u_buf0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push0),
        .data_i  (data_i),
        .ready_i (ready0_i),
        .data_o  (data0_o),
        .valid_o (valid0_o),
        .full_o  (full0)
    );

    demux_skid_buf #(.size(size)) u_buf1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push1),
        .data_i  (data_i),
        .ready_i (ready1_i),
        .data_o  (data1_o),
        .valid_o (valid1_o),
        .full_o  (full1)
    );

`ifdef DEMUX_1TO2_CNT_EN
    logic [CNT_W-1:0] pathCnt0_q, pathCnt0_d;
    logic [CNT_W-1:0] pathCnt1_q, pathCnt1_d;

    // Completed output transfers per path; wraps naturally at the counter width.
    always_comb begin
        pathCnt0_d = pathCnt0_q;
        pathCnt1_d = pathCnt1_q;
        if (valid0_o && ready0_i) begin
            pathCnt0_d = pathCnt0_q + CNT_W'(1);
        end
        if (valid1_o && ready1_i) begin
            pathCnt1_d = pathCnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pathCnt0_q <= '0;
            pathCnt1_q <= '0;
        end else begin
            pathCnt0_q <= pathCnt0_d;
            pathCnt1_q <= pathCnt1_d;
        end
    end

    always_comb begin
        cnt0_o = pathCnt0_q;
        cnt1_o = pathCnt1_q;
    end
`endif

endmodule

// File: tb/tb_demux_1to2_pipe.sv
// Directed self-checking bench for demux_1to2_pipe (size = 8).
// Counter checks are compiled in only when DEMUX_1TO2_CNT_EN is defined.
module tb_demux_1to2_pipe;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] data_i;
    logic       select_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data0_o;
    logic       valid0_o;
    logic       ready0_i;
    logic [7:0] data1_o;
    logic       valid1_o;
    logic       ready1_i;
`ifdef DEMUX_1TO2_CNT_EN
    logic [15:0] cnt0_o;
    logic [15:0] cnt1_o;
`endif

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk_i = ~clk_i;

    demux_1to2_pipe #(.size(8)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .select_i (select_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data0_o  (data0_o),
        .valid0_o (valid0_o),
        .ready0_i (ready0_i),
        .data1_o  (data1_o),
        .valid1_o (valid1_o),
        .ready1_i (ready1_i)
`ifdef DEMUX_1TO2_CNT_EN
        ,
        .cnt0_o   (cnt0_o),
        .cnt1_o   (cnt1_o)
`endif
    );

    // Inputs change on the falling edge, well away from the active edge.
    task automatic applyStimulus(input logic v, input logic sel, input logic [7:0] d,
                                 input logic r0, input logic r1);
        @(negedge clk_i);
        valid_i  = v;
        select_i = sel;
        data_i   = d;
        ready0_i = r0;
        ready1_i = r1;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    initial begin
        rst_i = 1'b0;
        applyStimulus(0, 0, 8'h00, 0, 0);
        stepClock();
        checkOutput("rst_valid0", 16'(valid0_o), 16'h0);
        checkOutput("rst_valid1", 16'(valid1_o), 16'h0);
        checkOutput("rst_data0", 16'(data0_o), 16'h0);
        checkOutput("rst_data1", 16'(data1_o), 16'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checkOutput("rst_ready", 16'(ready_o), 16'h1);

        // Route one word to each output.
        applyStimulus(1, 0, 8'hA5, 1, 1);
        stepClock();
        checkOutput("route_valid0", 16'(valid0_o), 16'h1);
        checkOutput("route_data0", 16'(data0_o), 16'h00A5);
        applyStimulus(1, 1, 8'h3C, 1, 1);
        stepClock();
        checkOutput("route_valid0_drop", 16'(valid0_o), 16'h0);
        checkOutput("route_valid1", 16'(valid1_o), 16'h1);
        checkOutput("route_data1", 16'(data1_o), 16'h003C);
        applyStimulus(0, 0, 8'h00, 1, 1);
        stepClock();
        checkOutput("route_valid1_drop", 16'(valid1_o), 16'h0);

        // Backpressure on output 0.
        applyStimulus(1, 0, 8'h11, 0, 1);
        checkOutput("bp_ready_11", 16'(ready_o), 16'h1);
        stepClock();
        applyStimulus(1, 0, 8'h22, 0, 1);
        checkOutput("bp_ready_22", 16'(ready_o), 16'h1);
        stepClock();
        applyStimulus(1, 0, 8'h33, 0, 1);
        checkOutput("bp_ready_full", 16'(ready_o), 16'h0);
        stepClock();
        checkOutput("bp_head0", 16'(data0_o), 16'h0011);
        checkOutput("bp_valid1_none", 16'(valid1_o), 16'h0);
        applyStimulus(1, 1, 8'h33, 0, 1);
        checkOutput("bp_ready_sel1", 16'(ready_o), 16'h1);
        stepClock();
        checkOutput("bp_valid1", 16'(valid1_o), 16'h1);
        checkOutput("bp_data1", 16'(data1_o), 16'h0033);

        // Release output 0 and drain in order.
        applyStimulus(0, 0, 8'h00, 1, 1);
        stepClock();
        checkOutput("rel_valid0_a", 16'(valid0_o), 16'h1);
        checkOutput("rel_data0_a", 16'(data0_o), 16'h0022);
        checkOutput("rel_valid1", 16'(valid1_o), 16'h0);
        applyStimulus(0, 0, 8'h00, 1, 1);
        stepClock();
        checkOutput("rel_valid0_b", 16'(valid0_o), 16'h0);
        checkOutput("rel_hold0", 16'(data0_o), 16'h0022);

        // Push and pop on the same edge with one entry queued.
        applyStimulus(1, 0, 8'h44, 0, 0);
        stepClock();
        checkOutput("sim_data0_44", 16'(data0_o), 16'h0044);
        applyStimulus(1, 0, 8'h55, 1, 0);
        checkOutput("sim_ready", 16'(ready_o), 16'h1);
        stepClock();
        checkOutput("sim_valid0", 16'(valid0_o), 16'h1);
        checkOutput("sim_data0_55", 16'(data0_o), 16'h0055);
        applyStimulus(0, 0, 8'h00, 1, 0);
        stepClock();
        checkOutput("sim_count_one", 16'(valid0_o), 16'h0);

        // Fill output 1; ready follows select combinationally.
        applyStimulus(1, 1, 8'h66, 0, 0);
        stepClock();
        applyStimulus(1, 1, 8'h77, 0, 0);
        stepClock();
        applyStimulus(1, 1, 8'h88, 0, 0);
        checkOutput("full1_ready_sel1", 16'(ready_o), 16'h0);
        applyStimulus(0, 0, 8'h88, 0, 0);
        checkOutput("full1_ready_sel0", 16'(ready_o), 16'h1);
        applyStimulus(1, 0, 8'h99, 0, 0);
        stepClock();
        checkOutput("full1_head1", 16'(data1_o), 16'h0066);
        checkOutput("full1_valid0", 16'(valid0_o), 16'h1);

        // Asynchronous reset while both buffers hold data.
        applyStimulus(0, 1, 8'h00, 0, 0);
        #2;
        rst_i = 1'b0;
        #1;
        checkOutput("arst_valid0", 16'(valid0_o), 16'h0);
        checkOutput("arst_valid1", 16'(valid1_o), 16'h0);
        checkOutput("arst_data0", 16'(data0_o), 16'h0);
        checkOutput("arst_data1", 16'(data1_o), 16'h0);
        stepClock();
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checkOutput("arst_ready_sel1", 16'(ready_o), 16'h1);
        stepClock();
        checkOutput("arst_stay_empty", 16'(valid1_o), 16'h0);

`ifdef DEMUX_1TO2_CNT_EN
        checkOutput("cnt0_reset", cnt0_o, 16'h0);
        checkOutput("cnt1_reset", cnt1_o, 16'h0);
        applyStimulus(1, 0, 8'h01, 1, 1);
        stepClock();
        stepClock();
        stepClock();
        applyStimulus(1, 1, 8'h02, 1, 1);
        stepClock();
        applyStimulus(0, 0, 8'h00, 1, 1);
        stepClock();
        checkOutput("cnt0_three", cnt0_o, 16'd3);
        checkOutput("cnt1_one", cnt1_o, 16'd1);
        applyStimulus(1, 0, 8'h03, 1, 1);
        for (int i = 0; i < 65532; i++) begin
            stepClock();
        end
        applyStimulus(0, 0, 8'h00, 1, 1);
        stepClock();
        checkOutput("cnt0_max", cnt0_o, 16'hFFFF);
        applyStimulus(1, 0, 8'h04, 1, 1);
        stepClock();
        applyStimulus(0, 0, 8'h00, 1, 1);
        stepClock();
        checkOutput("cnt0_wrap", cnt0_o, 16'h0000);
        checkOutput("cnt1_hold", cnt1_o, 16'd1);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
